// File: rtl/sys_arr_result_collector_pkg.sv
// Shared defaults and helpers for the systolic-array result collector.
package sys_arr_result_collector_pkg;

    localparam int row_width_def  = 8;
    localparam int sum_w_def      = 8;
    localparam int fifo_depth_def = 8;

    // Bits needed to address `value` entries (value >= 2).
    function automatic int sa_log2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/sys_arr_col_delay.sv
// One column of the deskew network: a valid-qualified shift register of
// `depth` stages; depth 0 is a plain wire.
module sys_arr_col_delay #(
    parameter int sum_w = 8,
    parameter int depth = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [sum_w-1:0] data_in,
    input  logic             vld_in,
    output logic [sum_w-1:0] data_out,
    output logic             vld_out
);

    generate
        if (depth == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst_n, clr};
            assign data_out   = data_in;
            assign vld_out    = vld_in;
        end else begin : g_shift
            logic [sum_w-1:0] data_q [depth];
            logic [depth-1:0] vld_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                end else if (clr) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= vld_in;
                    for (int k = 1; k < depth; k++) vld_q[k] <= vld_q[k-1];
                end
            end

            // Data only moves alongside a valid bit, so idle columns do not toggle.
            always_ff @(posedge clk) begin
                if (vld_in) data_q[0] <= data_in;
                for (int k = 1; k < depth; k++) begin
                    if (vld_q[k-1]) data_q[k] <= data_q[k-1];
                end
            end

            assign data_out = data_q[depth-1];
            assign vld_out  = vld_q[depth-1];
        end
    endgenerate

endmodule

// File: rtl/sys_arr_result_collector.sv
// Deskews the systolic array's column sums, reassembles aligned rows and
// buffers them in a small FIFO with a valid/ready output.
module sys_arr_result_collector
    import sys_arr_result_collector_pkg::*;
#(
    parameter int row_width  = row_width_def,
    parameter int sum_w      = sum_w_def,
    parameter int fifo_depth = fifo_depth_def
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [row_width*sum_w-1:0] mac_in,
    input  logic [row_width-1:0]       valid_in,
    output logic [row_width*sum_w-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 rows_done,
    output logic                       overflow,
    output logic                       skew_err
);

    localparam int              row_w    = row_width * sum_w;
    localparam int              ptr_w    = sa_log2(fifo_depth);
    localparam logic [ptr_w:0]  full_cnt = (ptr_w+1)'(fifo_depth);

    logic [row_w-1:0]     row_data;
    logic [row_width-1:0] dly_vld;
    logic                 row_vld;
    logic                 any_vld;

    // Column j waits row_width-1-j cycles so every column lines up with the last one.
    genvar j;
    generate
        for (j = 0; j < row_width; j++) begin : g_col
            sys_arr_col_delay #(
                .sum_w (sum_w),
                .depth (row_width - 1 - j)
            ) u_dly (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (clr),
                .data_in  (mac_in[j*sum_w +: sum_w]),
                .vld_in   (valid_in[j]),
                .data_out (row_data[j*sum_w +: sum_w]),
                .vld_out  (dly_vld[j])
            );
        end
    endgenerate

    assign row_vld = &dly_vld;
    assign any_vld = |dly_vld;

    logic [row_w-1:0] mem [fifo_depth];
    logic [ptr_w-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [ptr_w:0]   count, count_nxt;
    logic [row_w-1:0] head_nxt;
    logic             full, pop, push, drop;

    assign out_valid = (count != '0);

    always_comb begin
        full       = (count == full_cnt);
        pop        = out_valid & out_ready;
        push       = row_vld & (~full | pop);
        drop       = row_vld & full & ~pop;
        rd_ptr_nxt = pop  ? rd_ptr + ptr_w'(1) : rd_ptr;
        wr_ptr_nxt = push ? wr_ptr + ptr_w'(1) : wr_ptr;
        unique case ({push, pop})
            2'b10:   count_nxt = count + (ptr_w+1)'(1);
            2'b01:   count_nxt = count - (ptr_w+1)'(1);
            default: count_nxt = count;
        endcase
        // The row being written becomes the head when nothing older remains.
        if (count_nxt == '0)
            head_nxt = out_data;
        else if (push && (wr_ptr == rd_ptr_nxt))
            head_nxt = row_data;
        else
            head_nxt = mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= row_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_data  <= '0;
            rows_done <= '0;
            overflow  <= 1'b0;
            skew_err  <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_data  <= '0;
            rows_done <= '0;
            overflow  <= 1'b0;
            skew_err  <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            out_data <= head_nxt;
            if (push)               rows_done <= rows_done + 8'd1;
            if (drop)               overflow  <= 1'b1;
            if (any_vld && !row_vld) skew_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sys_arr_result_collector.sv
// Self-checking bench: a row-level queue model is compared every cycle,
// plus a scenario table and hand-written corner-case sequences.
module tb_sys_arr_result_collector;

    logic        clk = 1'b0;
    logic        rst_n, clr, out_ready, out_valid, overflow, skew_err;
    logic [63:0] mac_in, out_data;
    logic [7:0]  valid_in, rows_done;

    always #5 clk = ~clk;

    sys_arr_result_collector #(.row_width(8), .sum_w(8), .fifo_depth(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .mac_in    (mac_in),
        .valid_in  (valid_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rows_done (rows_done),
        .overflow  (overflow),
        .skew_err  (skew_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Per-cycle column schedule and per-edge row completion, ring-indexed by cycle.
    logic [63:0] sch_data [64];
    logic [7:0]  sch_vld  [64];
    logic [63:0] done_d   [64];
    logic [7:0]  done_m   [64];

    logic [63:0] mq[$];
    logic [7:0]  m_rows;
    bit          m_ovf, m_skew;
    logic [63:0] last_head;
    logic [63:0] dut_pops[$];

    typedef struct {
        int n_rows;
        int gap;
        bit ready;
        bit idx_data;
        int exp_done;
        bit exp_ovf;
    } scen_t;
    scen_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rows    = 8'd0;
        m_ovf     = 1'b0;
        m_skew    = 1'b0;
        last_head = 64'd0;
        for (int i = 0; i < 64; i++) begin
            sch_vld[i] = 8'd0;
            done_m[i]  = 8'd0;
        end
    endtask

    task automatic check_outputs();
        if (mq.size() != 0) last_head = mq[0];
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check("out_data",  out_data, last_head);
        check("rows_done", 64'(rows_done), 64'(m_rows));
        check("overflow",  64'(overflow), 64'(m_ovf));
        check("skew_err",  64'(skew_err), 64'(m_skew));
    endtask

    // Row starting now: column j appears j cycles later; row completes 7 cycles later.
    task automatic launch_row(input logic [63:0] d, input logic [7:0] m);
        int s;
        for (int j = 0; j < 8; j++) begin
            s = (cyc + j) % 64;
            if (m[j]) begin
                sch_vld[s][j]         = 1'b1;
                sch_data[s][j*8 +: 8] = d[j*8 +: 8];
            end
        end
        done_d[(cyc + 7) % 64] = d;
        done_m[(cyc + 7) % 64] = m;
    endtask

    task automatic step();
        int          s;
        bit          pop, clr_now;
        logic [63:0] junk;
        s    = cyc % 64;
        junk = {$urandom, $urandom};
        for (int j = 0; j < 8; j++)
            mac_in[j*8 +: 8] = sch_vld[s][j] ? sch_data[s][j*8 +: 8] : junk[j*8 +: 8];
        valid_in = sch_vld[s];
        pop      = (mq.size() != 0) && out_ready;
        clr_now  = clr;
        if (out_valid && out_ready && !clr) dut_pops.push_back(out_data);
        @(posedge clk);
        if (clr_now) begin
            model_reset();
        end else begin
            if (pop) void'(mq.pop_front());
            if (done_m[s] == 8'hFF) begin
                if (mq.size() < 8) begin
                    mq.push_back(done_d[s]);
                    m_rows = m_rows + 8'd1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (done_m[s] != 8'h00) begin
                m_skew = 1'b1;
            end
        end
        sch_vld[s] = 8'd0;
        done_m[s]  = 8'd0;
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        clr       = 1'b0;
        valid_in  = 8'd0;
        out_ready = 1'b0;
        model_reset();
        dut_pops.delete();
        #1;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        logic [63:0] row_x;
        int          early;

        tbl[0] = '{n_rows: 8,  gap: 1, ready: 1'b1, idx_data: 1'b1, exp_done: 8,  exp_ovf: 1'b0};
        tbl[1] = '{n_rows: 9,  gap: 1, ready: 1'b0, idx_data: 1'b1, exp_done: 8,  exp_ovf: 1'b1};
        tbl[2] = '{n_rows: 5,  gap: 3, ready: 1'b1, idx_data: 1'b0, exp_done: 5,  exp_ovf: 1'b0};
        tbl[3] = '{n_rows: 20, gap: 1, ready: 1'b1, idx_data: 1'b1, exp_done: 20, exp_ovf: 1'b0};
        tbl[4] = '{n_rows: 12, gap: 2, ready: 1'b0, idx_data: 1'b0, exp_done: 8,  exp_ovf: 1'b1};

        rst_n = 1'b0; clr = 1'b0; out_ready = 1'b0; valid_in = 8'd0; mac_in = 64'd0;
        apply_reset();

        // Single skewed row: exact latency.
        out_ready = 1'b1;
        repeat (3) step();
        launch_row(64'h1716151413121110, 8'hFF);
        for (int k = 0; k < 7; k++) begin
            step();
            check("t1_no_early_valid", 64'(out_valid), 64'd0);
        end
        step();
        check("t1_valid",     64'(out_valid), 64'd1);
        check("t1_data",      out_data, 64'h1716151413121110);
        check("t1_rows_done", 64'(rows_done), 64'd1);
        step();
        check("t1_one_cycle", 64'(out_valid), 64'd0);

        // Scenario table: streaming, backpressure, overflow.
        for (int i = 0; i < 5; i++) begin
            apply_reset();
            out_ready = tbl[i].ready;
            for (int r = 0; r < tbl[i].n_rows; r++) begin
                launch_row(tbl[i].idx_data ? {8{8'(r)}} : {$urandom, $urandom}, 8'hFF);
                repeat (tbl[i].gap) step();
            end
            repeat (10) step();
            check("scen_rows_done", 64'(rows_done), 64'(tbl[i].exp_done));
            check("scen_overflow",  64'(overflow),  64'(tbl[i].exp_ovf));
            check("scen_skew_err",  64'(skew_err),  64'd0);
            out_ready = 1'b1;
            repeat (12) step();
            check("scen_popped", 64'(dut_pops.size()), 64'(tbl[i].exp_done));
            if (tbl[i].idx_data)
                for (int k = 0; k < dut_pops.size(); k++)
                    check("scen_order", dut_pops[k], {8{8'(k)}});
        end

        // Push and pop in the same cycle while full.
        apply_reset();
        for (int r = 0; r < 8; r++) begin
            launch_row({8{8'(8'hA0 + r)}}, 8'hFF);
            step();
        end
        repeat (8) step();
        check("full_valid",     64'(out_valid), 64'd1);
        check("full_rows_done", 64'(rows_done), 64'd8);
        row_x = 64'hCAFE0123BEEF4567;
        launch_row(row_x, 8'hFF);
        repeat (7) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pp_overflow",  64'(overflow),  64'd0);
        check("pp_rows_done", 64'(rows_done), 64'd9);
        repeat (3) step();
        check("pp_hold", out_data, {8{8'hA1}});
        out_ready = 1'b1;
        repeat (10) step();
        check("pp_popped", 64'(dut_pops.size()), 64'd9);
        if (dut_pops.size() == 9) begin
            check("pp_first", dut_pops[0], {8{8'hA0}});
            check("pp_last",  dut_pops[8], row_x);
        end

        // Skew error: column 7 missing.
        apply_reset();
        out_ready = 1'b1;
        launch_row(64'h1111111111111111, 8'hFF);
        repeat (9) step();
        launch_row(64'h2222222222222222, 8'h7F);
        repeat (10) step();
        check("skew_flag",      64'(skew_err),        64'd1);
        check("skew_rows_done", 64'(rows_done),       64'd1);
        check("skew_pops",      64'(dut_pops.size()), 64'd1);
        check("skew_overflow",  64'(overflow),        64'd0);

        // Reset with three columns in flight.
        apply_reset();
        out_ready = 1'b1;
        launch_row(64'h0123456789ABCDEF, 8'hFF);
        repeat (3) step();
        apply_reset();
        out_ready = 1'b1;
        early = 0;
        repeat (10) begin
            step();
            if (out_valid || skew_err) early++;
        end
        check("rst_mid_spurious", 64'(early), 64'd0);
        launch_row(64'hFEDCBA9876543210, 8'hFF);
        repeat (9) step();
        check("rst_mid_rows_done", 64'(rows_done),       64'd1);
        check("rst_mid_pops",      64'(dut_pops.size()), 64'd1);
        if (dut_pops.size() == 1) check("rst_mid_data", dut_pops[0], 64'hFEDCBA9876543210);

        // Randomized traffic with backpressure, partial rows and clears.
        apply_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 1) == 0)
                launch_row({$urandom, $urandom},
                           ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'hFF);
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 199) == 0);
            step();
        end
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
